// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce, and derive press,
// release and long-press pulses for each key channel independently.
module button_debouncer #(
    parameter int NUM_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic [NUM_BUTTONS-1:0] long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [NUM_BUTTONS-1:0] IDLE_PIN =
        ACTIVE_LOW ? {NUM_BUTTONS{1'b1}} : {NUM_BUTTONS{1'b0}};

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] s_q, s_d;
    logic [NUM_BUTTONS-1:0] level_q, level_d;
    logic [NUM_BUTTONS-1:0] press_q, press_d;
    logic [NUM_BUTTONS-1:0] rel_q, rel_d;
    logic [NUM_BUTTONS-1:0] lp_q, lp_d;
    logic [NUM_BUTTONS-1:0] held_q, held_d;
    logic [DW-1:0] dcnt_q [NUM_BUTTONS];
    logic [DW-1:0] dcnt_d [NUM_BUTTONS];
    logic [LW-1:0] lcnt_q [NUM_BUTTONS];
    logic [LW-1:0] lcnt_d [NUM_BUTTONS];

    always_comb begin
        s_d     = ACTIVE_LOW ? ~sync2_q : sync2_q;
        level_d = level_q;
        held_d  = held_q;
        press_d = '0;
        rel_d   = '0;
        lp_d    = '0;
        dcnt_d  = dcnt_q;
        lcnt_d  = lcnt_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            // Any cycle agreeing with the accepted level restarts the count.
            if (s_q[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DMAX) begin
                level_d[i] = s_q[i];
                dcnt_d[i]  = '0;
                press_d[i] = s_q[i];
                rel_d[i]   = ~s_q[i];
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            if (!level_q[i]) begin
                lcnt_d[i] = '0;
                held_d[i] = 1'b0;
            end else if (!held_q[i]) begin
                if (lcnt_q[i] == LMAX) begin
                    lp_d[i]   = 1'b1;
                    held_d[i] = 1'b1;
                end else begin
                    lcnt_d[i] = lcnt_q[i] + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
            s_q     <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            lp_q    <= '0;
            held_q  <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                dcnt_q[i] <= '0;
                lcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_buttons;
            sync2_q <= sync1_q;
            s_q     <= s_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            lp_q    <= lp_d;
            held_q  <= held_d;
            dcnt_q  <= dcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign level      = level_q;
    assign pressed    = press_q;
    assign released   = rel_q;
    assign long_press = lp_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short debounce and long-press
// windows; all expected values are hand-derived per cycle.
module tb_button_debouncer;

    logic       Clock;
    logic       Reset;
    logic [3:0] raw;
    logic [3:0] level, pressed, released, long_press;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .NUM_BUTTONS(4),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .raw_buttons(raw),
        .level(level),
        .pressed(pressed),
        .released(released),
        .long_press(long_press)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Edge k of a loop is the k-th rising edge after new stimulus; the
    // first one samples it, so accepted changes appear on edge 7.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {level, pressed, released, long_press};
    endfunction

    task automatic test_reset();
        logic [15:0] e;
        Reset = 1'b1;
        raw   = 4'b0000;
        step();
        step();
        checks++;
        if (outs() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", outs(), 16'h0000);
        end
        Reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            e = {(i >= 7) ? 4'hF : 4'h0, (i == 7) ? 4'hF : 4'h0, 8'h00};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL reset_release edge %0d got %h exp %h", i, outs(), e);
            end
        end
        raw = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            step();
            e = {(i < 7) ? 4'hF : 4'h0, 4'h0, (i == 7) ? 4'hF : 4'h0, 4'h0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL reset_unpress edge %0d got %h exp %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [15:0] e;
        raw = 4'b1110;
        for (int i = 1; i <= 8; i++) begin
            step();
            e = {(i >= 7) ? 4'h1 : 4'h0, (i == 7) ? 4'h1 : 4'h0, 8'h00};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL clean_press edge %0d got %h exp %h", i, outs(), e);
            end
        end
        raw = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            step();
            e = {(i < 7) ? 4'h1 : 4'h0, 4'h0, (i == 7) ? 4'h1 : 4'h0, 4'h0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL clean_release edge %0d got %h exp %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            raw = 4'b1111;
            if (i < 20) raw[1] = ((i / 2) % 2) != 0;
            step();
            checks++;
            if (outs() !== 16'h0000) begin
                errors++;
                $display("FAIL bounce cycle %0d got %h exp %h", i, outs(), 16'h0000);
            end
        end
    endtask

    task automatic test_long_press();
        logic [15:0] e;
        raw = 4'b1011;
        for (int i = 1; i <= 30; i++) begin
            step();
            e = {(i >= 7) ? 4'h4 : 4'h0, (i == 7) ? 4'h4 : 4'h0,
                 4'h0, (i == 17) ? 4'h4 : 4'h0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL long_hold edge %0d got %h exp %h", i, outs(), e);
            end
        end
        raw = 4'b1111;
        for (int i = 1; i <= 20; i++) begin
            step();
            e = {(i < 7) ? 4'h4 : 4'h0, 4'h0, (i == 7) ? 4'h4 : 4'h0, 4'h0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL long_release edge %0d got %h exp %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_short_press();
        logic [15:0] e;
        for (int i = 1; i <= 24; i++) begin
            raw = (i <= 8) ? 4'b0111 : 4'b1111;
            step();
            e = {(i >= 7 && i < 15) ? 4'h8 : 4'h0, (i == 7) ? 4'h8 : 4'h0,
                 (i == 15) ? 4'h8 : 4'h0, 4'h0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL short_press edge %0d got %h exp %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        raw = 4'b1110;
        for (int i = 1; i <= 8; i++) step();
        checks++;
        if (outs() !== 16'h1000) begin
            errors++;
            $display("FAIL mid_setup got %h exp %h", outs(), 16'h1000);
        end
        raw = 4'b1111;
        for (int i = 1; i <= 5; i++) step();
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 16'h0000) begin
            errors++;
            $display("FAIL mid_async got %h exp %h", outs(), 16'h0000);
        end
        raw = 4'b1110;
        step();
        step();
        checks++;
        if (outs() !== 16'h0000) begin
            errors++;
            $display("FAIL mid_hold got %h exp %h", outs(), 16'h0000);
        end
        Reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            e = {(i >= 7) ? 4'h1 : 4'h0, (i == 7) ? 4'h1 : 4'h0, 8'h00};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL mid_restart edge %0d got %h exp %h", i, outs(), e);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        raw   = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_short_press();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
